// File: rtl/vibrato_engine.sv
// Vibrato delay line: circular sample buffer read back at BASE_DELAY plus a triangle-LFO offset.
// Latency: in_valid to out_valid is 2 cycles, fully pipelined, no backpressure (one output per input).
module vibrato_engine #(
   parameter int DATA_W     = 24,
   parameter int ADDR_W     = 10,
   parameter int BASE_DELAY = 16,
   parameter int MOD_DEPTH  = 256
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic [31:0]       frequency,
   input  logic              disabled,
   input  logic [DATA_W-1:0] in_sample,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_sample,
   output logic              out_valid
);

   localparam int OFF_W  = $clog2(MOD_DEPTH + 1);
   localparam int FILL_W = ADDR_W + 1;
   localparam logic [OFF_W-1:0]  OFF_TOP   = OFF_W'(MOD_DEPTH - 1);
   localparam logic [OFF_W-1:0]  OFF_ONE   = OFF_W'(1);
   localparam logic [FILL_W-1:0] FILL_FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {UP = 1'b0, DOWN = 1'b1} lfo_dir_t;

   typedef struct packed {
      logic              bypass;
      logic              mask;
      logic [DATA_W-1:0] byp_dat;
      logic [ADDR_W-1:0] rd_addr;
   } s1_t;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic [31:0]       step_cnt;
   logic [31:0]       step_lim;
   logic              step_fire;
   lfo_dir_t          lfo_dir;
   lfo_dir_t          lfo_dir_nxt;
   logic [OFF_W-1:0]  lfo_off;
   logic [OFF_W-1:0]  lfo_off_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [FILL_W-1:0] fill_cnt;
   logic [ADDR_W-1:0] delay;
   logic              s1_vld;
   s1_t               s1;

   // frequency=0 is treated as 1; >= lets a shrinking period fire immediately.
   assign step_lim  = (frequency == 32'd0) ? 32'd0 : frequency - 32'd1;
   assign step_fire = !disabled && (step_cnt >= step_lim);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         step_cnt <= 32'd0;
      end else if (!disabled) begin
         step_cnt <= step_fire ? 32'd0 : step_cnt + 32'd1;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         lfo_dir <= UP;
      end else begin
         lfo_dir <= lfo_dir_nxt;
      end
   end

   always_comb begin
      lfo_dir_nxt = lfo_dir;
      case (lfo_dir)
         UP:      if (step_fire && lfo_off == OFF_TOP) lfo_dir_nxt = DOWN;
         DOWN:    if (step_fire && lfo_off == OFF_ONE) lfo_dir_nxt = UP;
         default: lfo_dir_nxt = UP;
      endcase
   end

   always_comb begin
      lfo_off_nxt = lfo_off;
      if (step_fire) begin
         if (lfo_dir == UP) lfo_off_nxt = lfo_off + OFF_ONE;
         else               lfo_off_nxt = lfo_off - OFF_ONE;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         lfo_off <= '0;
      end else begin
         lfo_off <= lfo_off_nxt;
      end
   end

   // Pre-step lfo_off is used: the offset sampled here is the registered value.
   assign delay = ADDR_W'(BASE_DELAY) + ADDR_W'(lfo_off);

   always_ff @(posedge CLK) begin
      if (in_valid) mem[wr_ptr] <= in_sample;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
         s1_vld   <= 1'b0;
         s1       <= '0;
      end else begin
         s1_vld <= in_valid;
         if (in_valid) begin
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + FILL_W'(1);
            s1.bypass  <= disabled;
            s1.mask    <= (fill_cnt < FILL_W'(delay));
            s1.byp_dat <= in_sample;
            s1.rd_addr <= wr_ptr - delay;
         end
      end
   end

   // Buffer read lands directly in the output register; fill_cnt masks stale RAM.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_sample <= '0;
      end else begin
         out_valid <= s1_vld;
         if (s1_vld) begin
            if (s1.bypass)    out_sample <= s1.byp_dat;
            else if (s1.mask) out_sample <= '0;
            else              out_sample <= mem[s1.rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_vibrato_engine.sv
// Directed bench for vibrato_engine with a small delay-line / LFO reference model.
module tb_vibrato_engine;

   localparam int DATA_W = 24;
   localparam int BASE   = 16;
   localparam int MOD    = 256;

   logic              CLK = 1'b0;
   logic              reset_n = 1'b0;
   logic [31:0]       frequency = 32'hFFFF_FFFF;
   logic              disabled = 1'b1;
   logic [DATA_W-1:0] in_sample = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] out_sample;
   logic              out_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int hist[$];
   int exp_q[$];
   int m_off = 0;
   bit m_up  = 1'b1;
   bit mon_en = 1'b0;

   vibrato_engine #(.DATA_W(DATA_W), .ADDR_W(10), .BASE_DELAY(BASE), .MOD_DEPTH(MOD)) dut (
      .CLK        (CLK),
      .reset_n    (reset_n),
      .frequency  (frequency),
      .disabled   (disabled),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .out_sample (out_sample),
      .out_valid  (out_valid)
   );

   always #10 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (mon_en && out_valid) begin
         if (exp_q.size() == 0) check_eq("spurious_out_valid", 64'(out_valid), 64'd0);
         else check_eq("out_sample", 64'(out_sample), 64'(exp_q.pop_front()));
      end
   end

   task automatic do_reset();
      mon_en   = 1'b0;
      in_valid = 1'b0;
      reset_n  = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      reset_n = 1'b1;
      hist.delete();
      exp_q.delete();
      m_off = 0;
      m_up  = 1'b1;
   endtask

   task automatic model_step();
      if (m_up) begin
         m_off++;
         if (m_off == MOD) m_up = 1'b0;
      end else begin
         m_off--;
         if (m_off == 0) m_up = 1'b1;
      end
   endtask

   // Expected output for sample n is hist[n - (BASE + off at capture)], or 0 before the buffer fills.
   task automatic feed(input int cnt, input int gap, input bit lfo_run);
      for (int i = 0; i < cnt; i++) begin
         int n;
         int d;
         n = hist.size();
         d = BASE + m_off;
         in_valid  = 1'b1;
         in_sample = DATA_W'(n + 1);
         exp_q.push_back((n < d) ? 0 : hist[n - d]);
         hist.push_back(n + 1);
         @(posedge CLK);
         #1;
         in_valid = 1'b0;
         if (lfo_run) model_step();
         for (int g = 0; g < gap; g++) begin
            @(posedge CLK);
            #1;
            if (lfo_run) model_step();
         end
      end
   endtask

   task automatic drain(input string tag);
      repeat (4) @(posedge CLK);
      #1;
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;

      // Reset state and bypass timing.
      disabled = 1'b1;
      do_reset();
      @(negedge CLK);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_sample", 64'(out_sample), 64'd0);
      check_eq("rst_wr_ptr", 64'(dut.wr_ptr), 64'd0);
      check_eq("rst_lfo_off", 64'(dut.lfo_off), 64'd0);
      @(posedge CLK);
      #1;
      in_valid = 1'b1; in_sample = 24'h000100;
      @(negedge CLK);
      check_eq("byp_c0_valid", 64'(out_valid), 64'd0);
      @(posedge CLK);
      #1;
      in_valid = 1'b1; in_sample = 24'h000200;
      @(negedge CLK);
      check_eq("byp_c1_valid", 64'(out_valid), 64'd0);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(negedge CLK);
      check_eq("byp_c2_valid", 64'(out_valid), 64'd1);
      check_eq("byp_c2_sample", 64'(out_sample), 64'h100);
      @(negedge CLK);
      check_eq("byp_c3_valid", 64'(out_valid), 64'd1);
      check_eq("byp_c3_sample", 64'(out_sample), 64'h200);
      @(negedge CLK);
      check_eq("byp_c4_valid", 64'(out_valid), 64'd0);
      check_eq("byp_hold_sample", 64'(out_sample), 64'h200);

      // Frozen LFO, fixed 16-sample delay.
      frequency = 32'hFFFF_FFFF;
      disabled  = 1'b0;
      do_reset();
      mon_en = 1'b1;
      feed(20, 0, 1'b0);
      feed(12, 2, 1'b0);
      drain("ramp_all_out");

      // Triangle LFO with a step every 4 clocks.
      frequency = 32'd4;
      do_reset();
      repeat (1023) @(posedge CLK);
      #1;
      check_eq("lfo_1023_off", 64'(dut.lfo_off), 64'd255);
      @(posedge CLK);
      #1;
      check_eq("lfo_1024_off", 64'(dut.lfo_off), 64'd256);
      check_eq("lfo_1024_dir", 64'(dut.lfo_dir), 64'd1);
      repeat (4) @(posedge CLK);
      #1;
      check_eq("lfo_1028_off", 64'(dut.lfo_off), 64'd255);
      repeat (1020) @(posedge CLK);
      #1;
      check_eq("lfo_2048_off", 64'(dut.lfo_off), 64'd0);
      check_eq("lfo_2048_dir", 64'(dut.lfo_dir), 64'd0);
      repeat (4) @(posedge CLK);
      #1;
      check_eq("lfo_2052_off", 64'(dut.lfo_off), 64'd1);

      // Shrinking the step period below step_cnt fires on the next cycle.
      frequency = 32'd1000;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge CLK);
         if (dut.step_cnt == 32'd500) found = 1'b1;
      end
      check_eq("reach_step_500", 64'(found), 64'd1);
      check_eq("pre_shrink_off", 64'(dut.lfo_off), 64'd0);
      frequency = 32'd100;
      @(posedge CLK);
      #1;
      check_eq("shrink_step_cnt", 64'(dut.step_cnt), 64'd0);
      check_eq("shrink_off", 64'(dut.lfo_off), 64'd1);
      disabled = 1'b1;
      repeat (300) @(posedge CLK);
      #1;
      check_eq("frozen_off", 64'(dut.lfo_off), 64'd1);
      check_eq("frozen_step_cnt", 64'(dut.step_cnt), 64'd0);
      disabled = 1'b0;
      @(posedge CLK);
      #1;
      check_eq("resume_step_cnt", 64'(dut.step_cnt), 64'd1);

      // LFO stepping every clock, buffer pointer wraps.
      frequency = 32'd0;
      disabled  = 1'b0;
      do_reset();
      mon_en = 1'b1;
      feed(1100, 0, 1'b1);
      drain("wrap_all_out");
      check_eq("wrap_wr_ptr", 64'(dut.wr_ptr), 64'(1100 % 1024));
      check_eq("wrap_fill_sat", 64'(dut.fill_cnt), 64'd1024);

      // Reset with a sample in flight.
      frequency = 32'hFFFF_FFFF;
      do_reset();
      mon_en = 1'b1;
      feed(20, 0, 1'b0);
      drain("pre_abort_out");
      mon_en = 1'b0;
      in_valid  = 1'b1;
      in_sample = 24'h0ABCDE;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(posedge CLK);
      #1;
      reset_n = 1'b1;
      check_eq("abort_out_sample", 64'(out_sample), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check_eq("abort_no_valid", 64'(out_valid), 64'd0);
      end
      @(posedge CLK);
      #1;
      hist.delete();
      exp_q.delete();
      m_off  = 0;
      m_up   = 1'b1;
      mon_en = 1'b1;
      feed(20, 1, 1'b0);
      drain("post_abort_out");
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vibrato_engine.md
Name: vibrato_engine

Overview:
- Audio-path half of the vibrato effect. It consumes the LFO step period (`frequency`) and `disabled` from the vibrato parameter controller.
- Writes incoming samples into a circular delay buffer and reads them back at a delay swept by a triangle LFO, producing pitch vibrato.
- Sits between the codec receive path and the effect output mux, in the main clock domain.

Parameters:
- DATA_W, 24: audio sample width, two's complement.
- ADDR_W, 10: delay buffer address width; buffer depth is 2^ADDR_W samples.
- BASE_DELAY, 16: minimum delay in samples. Must be ≥1.
- MOD_DEPTH, 256: LFO peak offset in samples. One LFO period is 2*MOD_DEPTH steps. BASE_DELAY+MOD_DEPTH must be less than 2^ADDR_W.

Ports:
- CLK  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- frequency  in  32  clocks per LFO step (19531 gives 5 Hz at 50 MHz with MOD_DEPTH=256).
- disabled  in  1  1 selects bypass.
- in_sample  in  DATA_W  input audio sample.
- in_valid  in  1  one-cycle strobe; in_sample is valid in that cycle.
- out_sample  out  DATA_W  processed or bypassed sample.
- out_valid  out  1  one-cycle strobe for out_sample.

Behaviour:
- Reset (async assert, sync release): out_sample=0, out_valid=0, wr_ptr=0, fill_cnt=0, step_cnt=0, lfo_off=0, lfo_dir=UP. Buffer RAM contents are not cleared; fill_cnt masks stale data.
- LFO step counter:
  - step_cnt increments each CLK while disabled=0.
  - When step_cnt ≥ max(frequency,1)-1: step_cnt←0 and an LFO step fires.
  - Using ≥ means a frequency decrease below the current step_cnt fires on the next cycle with no wrap-through.
  - frequency=0 behaves as 1, i.e. a step every cycle.
- LFO states:
  - UP: on a step, lfo_off+1. On reaching MOD_DEPTH, go to DOWN.
  - DOWN: on a step, lfo_off-1. On reaching 0, go to UP.
  - lfo_off stays within 0..MOD_DEPTH. Period is 2*MOD_DEPTH steps.
- Disabled: step_cnt, lfo_off and lfo_dir freeze. The buffer keeps being written, so re-enabling resumes without refill.
- Pipeline (fully pipelined; back-to-back in_valid is legal; each in_valid produces exactly one out_valid):
  - Stage 0 (in_valid cycle):
    - Write in_sample to RAM[wr_ptr].
    - rd_addr ← wr_ptr - (BASE_DELAY + lfo_off), mod 2^ADDR_W.
    - Latch bypass ← disabled and byp_data ← in_sample.
    - Latch mask ← (fill_cnt < BASE_DELAY + lfo_off).
    - wr_ptr+1 (wraps).
    - fill_cnt+1, saturating at 2^ADDR_W.
  - Stage 1: synchronous RAM read of rd_addr. Read and write addresses never coincide because delay ≥ 1.
  - Stage 2: out_valid=1 for one cycle, and out_sample is set:
    - bypass=1: out_sample = byp_data.
    - mask=1: out_sample = 0.
    - otherwise: out_sample = RAM data.
  - Latency: in_valid to out_valid is exactly 2 cycles. out_sample holds its value between strobes.
- Delay semantics: output for input index n is the sample at index n-(BASE_DELAY+lfo_off). The lfo_off used is the value sampled in the in_valid cycle.
- An LFO step coinciding with in_valid: the pre-step lfo_off is used.
- A disabled toggle mid-pipeline: samples already in flight keep the mode latched at stage 0.
- Reset mid-operation: in-flight samples are discarded and no out_valid is produced after release. fill_cnt=0, so the first BASE_DELAY outputs after restart are 0.
- Arithmetic: the address subtraction wraps modulo 2^ADDR_W. There is no arithmetic on sample data.

Test Plan:
- Reset, disabled=1, in_valid pulses with in_sample=0x000100, 0x000200 -> out_valid exactly 2 cycles after each pulse; out_sample=0x000100, then 0x000200.
- disabled=0, frequency=0xFFFFFFFF (LFO effectively frozen at lfo_off=0), feed ramp 1,2,3,... -> first 16 outputs are 0; output k (k≥16) equals k-15, i.e. the input 16 samples earlier.
- disabled=0, frequency=4, no samples -> lfo_off increments every 4 cycles, reaches 256 at cycle 1024, then decrements; it is back to 0 at cycle 2048 with direction UP.
- frequency=1000 with step_cnt at 500, then frequency changed to 100 -> a step fires on the next cycle and step_cnt restarts at 0.
- Feed 1100 ramp samples with frequency=0 (step every cycle) -> wr_ptr wraps past 1023 with no glitch; each output equals input[n - 16 - lfo_off], with lfo_off captured at that input's in_valid cycle.
- Assert reset_n low for 1 cycle while in_valid was 1 cycle earlier -> no out_valid after release; out_sample=0; the next 16 enabled outputs are 0.
